// File: rtl/aes_block_loader_pkg.sv
// Shared definitions for the AES-128 block loader.
//   AES_BLOCK_W  : width of one AES block / key
//   AES_BYTES    : bytes per block
//   AES_PIPE_LAT : default latency of the 10-round pipelined encryption core
//   load_state_t : loader FSM states
package aes_block_loader_pkg;

  localparam int unsigned AES_BLOCK_W  = 128;
  localparam int unsigned AES_BYTES    = 16;
  localparam int unsigned AES_PIPE_LAT = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_KEY,
    LOAD_PT,
    ISSUE
  } load_state_t;

endpackage

// File: rtl/aes_valid_delay.sv
// PIPE_LAT-deep 1-bit shift register tracking blocks in flight through the core.
//   clock : system clock
//   reset : synchronous active-high reset, drops every in-flight bit
//   din   : issue strobe in
//   dout  : din delayed by exactly PIPE_LAT cycles
module aes_valid_delay #(
  parameter int unsigned PIPE_LAT = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [PIPE_LAT-1:0] sr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= din;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout = sr_q[PIPE_LAT-1];

endmodule

// File: rtl/aes_block_loader.sv
// Byte-serial feeder for the pipelined AES-128 encryption core.
//   clock        : system clock, all state on posedge
//   reset        : synchronous active-high reset
//   in_data      : input byte, byte 0 of a group lands in bits [127:120]
//   in_valid     : in_data valid
//   in_is_key    : group type, sampled on byte 0 of a group only
//   in_ready     : loader accepts a byte this cycle
//   plain_text   : last complete plaintext block
//   c_key        : last complete key
//   key_loaded   : a complete key has been loaded since reset
//   issue        : one-cycle strobe, plain_text/c_key form a new block
//   cipher_valid : issue delayed by PIPE_LAT, qualifies the core's dataout
module aes_block_loader
  import aes_block_loader_pkg::*;
#(
  parameter int unsigned PIPE_LAT = AES_PIPE_LAT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_is_key,
  output logic                   in_ready,
  output logic [AES_BLOCK_W-1:0] plain_text,
  output logic [AES_BLOCK_W-1:0] c_key,
  output logic                   key_loaded,
  output logic                   issue,
  output logic                   cipher_valid
);

  load_state_t            state_q, state_d;
  logic [3:0]             cnt_q;
  logic                   alive_q;
  logic [AES_BLOCK_W-1:0] key_shd_q, pt_shd_q;
  logic                   take, last_byte, to_key;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // alive_q keeps in_ready low for the first cycle after reset drops.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    to_key    = 1'b0;
    in_ready  = alive_q && (state_q != ISSUE);
    take      = in_valid && in_ready;
    last_byte = take && (state_q != IDLE) && (cnt_q == 4'(AES_BYTES - 1));
    case (state_q)
      IDLE: begin
        // Until a key exists, any group is absorbed as key.
        to_key = in_is_key || !key_loaded;
        if (take) state_d = to_key ? LOAD_KEY : LOAD_PT;
      end
      LOAD_KEY: begin
        to_key = 1'b1;
        if (last_byte) state_d = IDLE;
      end
      LOAD_PT: begin
        if (last_byte) state_d = ISSUE;
      end
      ISSUE: begin
        issue   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alive_q    <= 1'b0;
      cnt_q      <= '0;
      key_shd_q  <= '0;
      pt_shd_q   <= '0;
      c_key      <= '0;
      plain_text <= '0;
      key_loaded <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (take) begin
        cnt_q <= cnt_q + 4'd1;
        if (to_key) key_shd_q <= {key_shd_q[AES_BLOCK_W-9:0], in_data};
        else        pt_shd_q  <= {pt_shd_q[AES_BLOCK_W-9:0], in_data};
        if (last_byte) begin
          if (to_key) begin
            c_key      <= {key_shd_q[AES_BLOCK_W-9:0], in_data};
            key_loaded <= 1'b1;
          end else begin
            plain_text <= {pt_shd_q[AES_BLOCK_W-9:0], in_data};
          end
        end
      end
    end
  end

  aes_valid_delay #(
    .PIPE_LAT(PIPE_LAT)
  ) u_valid_delay (
    .clock(clock),
    .reset(reset),
    .din  (issue),
    .dout (cipher_valid)
  );

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: byte groups are kept as queues and
// blocks are rebuilt from them; issue times are recorded to predict cipher_valid.
module tb_aes_block_loader;

  localparam int unsigned PIPE_LAT = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_is_key = 1'b0;
  logic         in_ready;
  logic [127:0] plain_text, c_key;
  logic         key_loaded, issue, cipher_valid;

  aes_block_loader #(
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_is_key   (in_is_key),
    .in_ready    (in_ready),
    .plain_text  (plain_text),
    .c_key       (c_key),
    .key_loaded  (key_loaded),
    .issue       (issue),
    .cipher_valid(cipher_valid)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state: what the outputs should be in the current cycle.
  bit           m_ready = 1'b0, m_issue = 1'b0, m_kl = 1'b0, m_cv = 1'b0;
  logic [127:0] m_key = '0, m_pt = '0;
  logic [7:0]   grp[$];
  bit           grp_key;
  int unsigned  iss_q[$];
  int unsigned  cyc = 0;

  typedef struct {
    logic [7:0] d;
    bit         k;
    bit         first;
  } ent_t;
  ent_t dq[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit v, input logic [7:0] d, input bit k, output bit acc);
    logic [127:0] blk;
    bit nis;
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    in_is_key = k;
    acc = v && m_ready && !rst;
    @(posedge clock);
    if (rst) begin
      m_ready = 0; m_issue = 0; m_kl = 0; m_key = '0; m_pt = '0;
      grp.delete();
      iss_q.delete();
    end else begin
      nis = 0;
      if (acc) begin
        if (grp.size() == 0) grp_key = k || !m_kl;
        grp.push_back(d);
        if (grp.size() == 16) begin
          blk = '0;
          for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = grp[i];
          if (grp_key) begin
            m_key = blk;
            m_kl  = 1;
          end else begin
            m_pt = blk;
            nis  = 1;
          end
          grp.delete();
        end
      end
      m_issue = nis;
      m_ready = !nis;
      if (nis) iss_q.push_back(cyc + 1);
    end
    cyc++;
    m_cv = 0;
    foreach (iss_q[i]) if (iss_q[i] + PIPE_LAT == cyc) m_cv = 1;
    @(negedge clock);
    check("in_ready", 128'(in_ready), 128'(m_ready));
    check("issue", 128'(issue), 128'(m_issue));
    check("cipher_valid", 128'(cipher_valid), 128'(m_cv));
    check("key_loaded", 128'(key_loaded), 128'(m_kl));
    check("c_key", c_key, m_key);
    check("plain_text", plain_text, m_pt);
  endtask

  task automatic idle(input int unsigned n);
    bit acc;
    for (int unsigned i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, acc);
  endtask

  task automatic reset_for(input int unsigned n);
    bit acc;
    dq.delete();
    for (int unsigned i = 0; i < n; i++) cycle(1, 0, 8'h00, 0, acc);
  endtask

  task automatic push_group(input bit k, input logic [127:0] blk);
    ent_t e;
    for (int i = 0; i < 16; i++) begin
      e.d = blk[127-8*i -: 8];
      e.k = k;
      e.first = (i == 0);
      dq.push_back(e);
    end
  endtask

  // Streams queued bytes; gap_pct = chance of an idle cycle, toggle randomises
  // in_is_key on every non-first byte, limit caps the number of bytes consumed.
  task automatic run(input int unsigned gap_pct, input bit toggle, input int unsigned limit);
    int unsigned popped = 0;
    int unsigned budget = 0;
    bit acc, v, k;
    logic [7:0] d;
    while (dq.size() > 0 && popped < limit) begin
      if (budget > 4000) begin
        n_vec++;
        n_err++;
        $error("FAIL run_timeout: got %0d bytes pending expected 0", dq.size());
        break;
      end
      budget++;
      v = ($urandom_range(99) >= gap_pct);
      d = v ? dq[0].d : 8'($urandom);
      k = (dq[0].first || !toggle) ? dq[0].k : 1'($urandom_range(1));
      cycle(0, v, d, k, acc);
      if (acc) begin
        void'(dq.pop_front());
        popped++;
      end
    end
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] tmp;

  initial begin
    // Reset state
    reset_for(3);

    // FIPS-197 key, then plaintext
    push_group(1, FIPS_KEY);
    run(0, 0, 1000);
    check("fips_key", c_key, FIPS_KEY);
    check("fips_key_loaded", 128'(key_loaded), 128'(1));
    push_group(0, FIPS_PT);
    run(0, 0, 1000);
    check("fips_issue", 128'(issue), 128'(1));
    check("fips_pt", plain_text, FIPS_PT);
    idle(PIPE_LAT + 3);

    // Plaintext-tagged group with no key is absorbed as key
    reset_for(2);
    tmp = rnd_blk();
    push_group(0, tmp);
    run(0, 0, 1000);
    idle(2);
    check("absorb_key", c_key, tmp);
    check("absorb_pt_untouched", plain_text, 128'h0);

    // Back-to-back plaintext groups
    for (int i = 0; i < 3; i++) push_group(0, rnd_blk());
    run(0, 0, 1000);
    idle(PIPE_LAT + 2);

    // Reset mid-group with a block in flight, then a fresh key group
    for (int i = 0; i < 3; i++) push_group(0, rnd_blk());
    run(0, 0, 16 * 2 + 7);
    reset_for(1);
    idle(PIPE_LAT + 3);
    tmp = rnd_blk();
    push_group(1, tmp);
    run(0, 0, 1000);
    check("key_after_reset", c_key, tmp);

    // Random gaps, in_is_key toggled mid-group, occasional key reload
    for (int g = 0; g < 8; g++) push_group($urandom_range(3) == 0, rnd_blk());
    run(40, 1, 1000);
    idle(PIPE_LAT + 2);

    // Key reload while a block is in flight
    push_group(0, rnd_blk());
    push_group(1, rnd_blk());
    run(0, 0, 1000);
    idle(PIPE_LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
